// File: rtl/pattern_detector_param.sv
// Sliding-window pattern detector for a valid-qualified symbol stream.
// The pattern can be reprogrammed at runtime. There are two reporting
// modes: a held flag with an ack handshake, or a one-cycle pulse per
// match with overlapping matches allowed.
// Ports:
//   clk           - clock; all state updates on the rising edge
//   reset_sync    - asynchronous, active-low reset
//   data_valid    - data holds a new symbol this cycle
//   data          - stream symbol (DATA_W bits)
//   pat_load      - load pat_in into the pattern register
//   pat_in        - new pattern; the MS symbol is matched first
//   ack           - host acknowledge / arm
//   found_pattern - registered detection flag
//   match_count   - saturating count of detections
//   busy          - high while a detection awaits its handshake
module pattern_detector_param #(
  parameter int unsigned                        DATA_W        = 8,
  parameter int unsigned                        PAT_LEN       = 4,
  parameter logic [PAT_LEN*DATA_W-1:0]          RESET_PATTERN = 32'h626F6D62,
  parameter bit                                 ACK_MODE      = 1'b1,
  parameter int unsigned                        CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      reset_sync,
  input  logic                      data_valid,
  input  logic [DATA_W-1:0]         data,
  input  logic                      pat_load,
  input  logic [PAT_LEN*DATA_W-1:0] pat_in,
  input  logic                      ack,
  output logic                      found_pattern,
  output logic [CNT_W-1:0]          match_count,
  output logic                      busy
);

  localparam int unsigned PAT_W  = PAT_LEN * DATA_W;
  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HUNT     = 2'd1,
    S_FOUND    = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   window_q, window_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               found_q, found_d;
  logic               busy_q, busy_d;
  logic [PAT_W-1:0]   window_shift_c;
  logic               load_ok_c;
  logic               match_c;

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      state_q   <= S_IDLE;
      window_q  <= '0;
      pattern_q <= RESET_PATTERN;
      fill_q    <= '0;
      count_q   <= '0;
      found_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      pattern_q <= pattern_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      found_q   <= found_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, window/fill update, match detection and counter
  always_comb begin
    state_d        = state_q;
    window_d       = window_q;
    pattern_d      = pattern_q;
    fill_d         = fill_q;
    count_d        = count_q;
    match_c        = 1'b0;
    window_shift_c = {window_q[PAT_W-DATA_W-1:0], data};
    load_ok_c      = pat_load && ((state_q == S_IDLE) || (state_q == S_HUNT));

    unique case (state_q)
      S_IDLE: begin
        if (ack) state_d = S_HUNT;
      end
      S_HUNT: begin
        // A pattern load in the same cycle wins over the symbol
        if (data_valid && !load_ok_c) begin
          window_d = window_shift_c;
          if (fill_q != FILL_W'(PAT_LEN)) fill_d = fill_q + FILL_W'(1);
          if ((fill_q >= FILL_W'(PAT_LEN - 1)) && (window_shift_c == pattern_q)) begin
            match_c = 1'b1;
            // Handshake mode restarts from an empty window; pulse mode keeps
            // the window so overlapping matches are found
            if (ACK_MODE) begin
              state_d  = S_FOUND;
              window_d = '0;
              fill_d   = '0;
            end
          end
        end
      end
      S_FOUND: begin
        if (!ack) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack) state_d = S_HUNT;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_ok_c) begin
      pattern_d = pat_in;
      window_d  = '0;
      fill_d    = '0;
    end

    if (match_c && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);

    found_d = ACK_MODE ? ((state_d == S_FOUND) || (state_d == S_WAIT_ACK)) : match_c;
    busy_d  = ACK_MODE && ((state_d == S_FOUND) || (state_d == S_WAIT_ACK));
  end

  assign found_pattern = found_q;
  assign match_count   = count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed, table-driven bench for pattern_detector_param.
// Three instances share the stimulus: u_ack (handshake mode), u_pls (pulse
// mode) and u_sat (pulse mode with a 2-bit counter). Each phase checks the
// instance it targets.
module tb_pattern_detector_param;

  logic        clk = 1'b0;
  logic        reset_sync;
  logic        data_valid;
  logic [7:0]  data;
  logic        pat_load;
  logic [31:0] pat_in;
  logic        ack;

  logic        f_ack, f_pls, f_sat;
  logic [7:0]  c_ack, c_pls;
  logic [1:0]  c_sat;
  logic        b_ack, b_pls, b_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pattern_detector_param #(.ACK_MODE(1'b1)) u_ack (
    .clk(clk), .reset_sync(reset_sync), .data_valid(data_valid), .data(data),
    .pat_load(pat_load), .pat_in(pat_in), .ack(ack),
    .found_pattern(f_ack), .match_count(c_ack), .busy(b_ack));

  pattern_detector_param #(.ACK_MODE(1'b0)) u_pls (
    .clk(clk), .reset_sync(reset_sync), .data_valid(data_valid), .data(data),
    .pat_load(pat_load), .pat_in(pat_in), .ack(ack),
    .found_pattern(f_pls), .match_count(c_pls), .busy(b_pls));

  pattern_detector_param #(.ACK_MODE(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .reset_sync(reset_sync), .data_valid(data_valid), .data(data),
    .pat_load(pat_load), .pat_in(pat_in), .ack(ack),
    .found_pattern(f_sat), .match_count(c_sat), .busy(b_sat));

  typedef struct {
    bit          sel;    // 0: check u_ack, 1: check u_pls
    logic        valid;
    logic [7:0]  d;
    logic        pl;
    logic [31:0] pi;
    logic        ak;
    logic        ef;
    logic [7:0]  ec;
    logic        eb;
  } vec_t;

  vec_t tab_ack[$];
  vec_t tab_pls[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit sel, logic v, logic [7:0] d, logic pl,
                              logic [31:0] pi, logic ak, logic ef,
                              logic [7:0] ec, logic eb);
    vec_t t;
    t.sel = sel; t.valid = v; t.d = d; t.pl = pl; t.pi = pi; t.ak = ak;
    t.ef = ef; t.ec = ec; t.eb = eb;
    return t;
  endfunction

  // Drive one cycle of inputs, clock it, and compare one edge later
  task automatic apply(input vec_t t, input int idx);
    data_valid = t.valid; data = t.d; pat_load = t.pl; pat_in = t.pi; ack = t.ak;
    @(posedge clk); #1;
    if (!t.sel) begin
      chk($sformatf("ack_found[%0d]", idx), int'(f_ack), int'(t.ef));
      chk($sformatf("ack_count[%0d]", idx), int'(c_ack), int'(t.ec));
      chk($sformatf("ack_busy[%0d]",  idx), int'(b_ack), int'(t.eb));
    end else begin
      chk($sformatf("pls_found[%0d]", idx), int'(f_pls), int'(t.ef));
      chk($sformatf("pls_count[%0d]", idx), int'(c_pls), int'(t.ec));
      chk($sformatf("pls_busy[%0d]",  idx), int'(b_pls), int'(t.eb));
    end
  endtask

  task automatic do_reset();
    data_valid = 1'b0; data = '0; pat_load = 1'b0; pat_in = '0; ack = 1'b0;
    reset_sync = 1'b0;
    #2;
    chk("rst_found_ack", int'(f_ack), 0);
    chk("rst_count_ack", int'(c_ack), 0);
    chk("rst_busy_ack",  int'(b_ack), 0);
    chk("rst_found_pls", int'(f_pls), 0);
    chk("rst_count_pls", int'(c_pls), 0);
    chk("rst_count_sat", int'(c_sat), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_sync = 1'b1;
  endtask

  initial begin
    // Handshake mode: basic detection and handshake
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 1, 0, 0, 0)); // arm
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 1, 0, 0, 0));
    tab_ack.push_back(mk(0, 1, 8'h6F, 0, '0, 1, 0, 0, 0));
    tab_ack.push_back(mk(0, 1, 8'h6D, 0, '0, 1, 0, 0, 0));
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 1, 1, 1, 1)); // match
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 1, 1, 1, 1)); // FOUND holds
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 0, 1, 1, 1)); // -> WAIT_ACK
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 0, 1, 1, 1)); // symbol discarded
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 1, 0, 1, 0)); // -> HUNT
    // Partial-match restart: 62 6F 62 6F 6D 62
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 0, 0, 1, 0));
    tab_ack.push_back(mk(0, 1, 8'h6F, 0, '0, 0, 0, 1, 0));
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 0, 0, 1, 0));
    tab_ack.push_back(mk(0, 1, 8'h6F, 0, '0, 0, 0, 1, 0));
    tab_ack.push_back(mk(0, 1, 8'h6D, 0, '0, 0, 0, 1, 0));
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 0, 1, 2, 1));
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 0, 1, 2, 1)); // WAIT_ACK
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 1, 0, 2, 0)); // -> HUNT
    // Gap of three idle cycles between 6F and 6D
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 0, 0, 2, 0));
    tab_ack.push_back(mk(0, 1, 8'h6F, 0, '0, 0, 0, 2, 0));
    tab_ack.push_back(mk(0, 0, 8'h6D, 0, '0, 0, 0, 2, 0));
    tab_ack.push_back(mk(0, 0, 8'h6D, 0, '0, 0, 0, 2, 0));
    tab_ack.push_back(mk(0, 0, 8'h6D, 0, '0, 0, 0, 2, 0));
    tab_ack.push_back(mk(0, 1, 8'h6D, 0, '0, 0, 0, 2, 0));
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 0, 1, 3, 1));
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 0, 1, 3, 1));
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 1, 0, 3, 0));
    // pat_load with data_valid: symbol dropped and window cleared
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 0, 0, 3, 0));
    tab_ack.push_back(mk(0, 1, 8'h6F, 0, '0, 0, 0, 3, 0));
    tab_ack.push_back(mk(0, 1, 8'h6D, 1, 32'h626F6D62, 0, 0, 3, 0));
    tab_ack.push_back(mk(0, 1, 8'h62, 0, '0, 0, 0, 3, 0)); // no match
    // Load a new pattern and detect it
    tab_ack.push_back(mk(0, 0, 8'h00, 1, 32'h01020304, 0, 0, 3, 0));
    tab_ack.push_back(mk(0, 1, 8'h01, 0, '0, 0, 0, 3, 0));
    tab_ack.push_back(mk(0, 1, 8'h02, 0, '0, 0, 0, 3, 0));
    tab_ack.push_back(mk(0, 1, 8'h03, 0, '0, 0, 0, 3, 0));
    tab_ack.push_back(mk(0, 1, 8'h04, 0, '0, 0, 1, 4, 1));
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 0, 1, 4, 1));
    tab_ack.push_back(mk(0, 0, 8'h00, 0, '0, 1, 0, 4, 0));

    // Pulse mode: overlapping matches on pattern 62626262
    tab_pls.push_back(mk(1, 0, 8'h00, 0, '0, 1, 0, 0, 0)); // arm
    tab_pls.push_back(mk(1, 0, 8'h00, 1, 32'h62626262, 0, 0, 0, 0));
    tab_pls.push_back(mk(1, 1, 8'h62, 0, '0, 0, 0, 0, 0));
    tab_pls.push_back(mk(1, 1, 8'h62, 0, '0, 0, 0, 0, 0));
    tab_pls.push_back(mk(1, 1, 8'h62, 0, '0, 0, 0, 0, 0));
    tab_pls.push_back(mk(1, 1, 8'h62, 0, '0, 0, 1, 1, 0));
    tab_pls.push_back(mk(1, 1, 8'h62, 0, '0, 0, 1, 2, 0));
    tab_pls.push_back(mk(1, 1, 8'h62, 0, '0, 0, 1, 3, 0));
    tab_pls.push_back(mk(1, 0, 8'h62, 0, '0, 0, 0, 3, 0)); // pulse ends
    tab_pls.push_back(mk(1, 1, 8'h62, 0, '0, 0, 1, 4, 0)); // window kept
    tab_pls.push_back(mk(1, 1, 8'h62, 0, '0, 0, 1, 5, 0));

    do_reset();
    foreach (tab_ack[i]) apply(tab_ack[i], i);

    do_reset();
    foreach (tab_pls[i]) begin
      apply(tab_pls[i], i);
      if (i == 5) chk("sat_count_1", int'(c_sat), 1);
    end
    chk("sat_count_hold", int'(c_sat), 3);
    chk("sat_busy", int'(b_sat), 0);

    // Reset between the 3rd and 4th symbol; pattern reverts to default
    do_reset();
    apply(mk(0, 0, 8'h00, 0, '0, 1, 0, 0, 0), 100);
    apply(mk(0, 1, 8'h62, 0, '0, 0, 0, 0, 0), 101);
    apply(mk(0, 1, 8'h6F, 0, '0, 0, 0, 0, 0), 102);
    apply(mk(0, 1, 8'h6D, 0, '0, 0, 0, 0, 0), 103);
    reset_sync = 1'b0;
    #2;
    chk("midmatch_rst_found", int'(f_ack), 0);
    reset_sync = 1'b1;
    apply(mk(0, 1, 8'h62, 0, '0, 0, 0, 0, 0), 104); // not armed
    apply(mk(0, 0, 8'h00, 0, '0, 1, 0, 0, 0), 105); // re-arm
    apply(mk(0, 1, 8'h62, 0, '0, 0, 0, 0, 0), 106); // window was cleared
    apply(mk(0, 1, 8'h6F, 0, '0, 0, 0, 0, 0), 107);
    apply(mk(0, 1, 8'h6D, 0, '0, 0, 0, 0, 0), 108);
    apply(mk(0, 1, 8'h62, 0, '0, 0, 1, 1, 1), 109);
    apply(mk(0, 0, 8'h00, 0, '0, 0, 1, 1, 1), 110); // WAIT_ACK

    // Reset in WAIT_ACK: outputs clear without a clock edge
    reset_sync = 1'b0;
    #2;
    chk("waitack_rst_found", int'(f_ack), 0);
    chk("waitack_rst_count", int'(c_ack), 0);
    chk("waitack_rst_busy",  int'(b_ack), 0);
    reset_sync = 1'b1;
    apply(mk(0, 1, 8'h62, 0, '0, 0, 0, 0, 0), 111);
    apply(mk(0, 1, 8'h6F, 0, '0, 0, 0, 0, 0), 112);
    apply(mk(0, 1, 8'h6D, 0, '0, 0, 0, 0, 0), 113);
    apply(mk(0, 1, 8'h62, 0, '0, 0, 0, 0, 0), 114); // idle: no detection

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
